// File: rtl/mul_err_stats_pkg.sv
// Shared types and constants for the multiplier error-statistics block.
package mul_err_stats_pkg;

  // Run-control states.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned DefPw   = 32;
  localparam int unsigned DefCntW = 16;

  // Accumulator width needed to sum 2^cnt_w values of base_w bits without wrap.
  function automatic int unsigned acc_width(input int unsigned base_w, input int unsigned cnt_w);
    return base_w + cnt_w;
  endfunction

endpackage

// File: rtl/mul_err_absdiff.sv
// Registered |a-b| stage with a mismatch flag and a valid bit.
module mul_err_absdiff #(
  parameter int unsigned W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_valid,
  output logic [W-1:0] o_d,
  output logic         o_ne
);

  logic [W:0]   w_diff;
  logic [W-1:0] w_mag;
  logic         r_valid;
  logic [W-1:0] r_d;
  logic         r_ne;

  // Signed difference in W+1 bits; the magnitude always fits back into W bits.
  always_comb begin
    w_diff = {1'b0, i_a} - {1'b0, i_b};
    w_mag  = w_diff[W] ? W'(~w_diff + 1'b1) : w_diff[W-1:0];
  end

  // Capture magnitude and mismatch flag for each accepted pair.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_d     <= '0;
      r_ne    <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_d  <= w_mag;
        r_ne <= (i_a != i_b);
      end
    end
  end

  assign o_valid = r_valid;
  assign o_d     = r_d;
  assign o_ne    = r_ne;

endmodule

// File: rtl/mul_err_stats.sv
// Error metrics (sum |e|, max |e|, error count) over a fixed-length run of
// {approx, exact} product pairs. Define MUL_ERR_STATS_SQERR_EN to add a
// registered squaring stage and the sum-of-squared-error output o_sum_se.
module mul_err_stats
  import mul_err_stats_pkg::*;
#(
  parameter int unsigned PW        = DefPw,
  parameter int unsigned N_SAMPLES = 1024,
  parameter int unsigned CNT_W     = DefCntW
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_start,
  input  logic                               i_in_valid,
  output logic                               o_in_ready,
  input  logic [PW-1:0]                      i_in_approx,
  input  logic [PW-1:0]                      i_in_exact,
  output logic                               o_busy,
  output logic                               o_done,
  output logic [acc_width(PW, CNT_W)-1:0]    o_sum_ae,
  output logic [PW-1:0]                      o_max_ae,
  output logic [CNT_W:0]                     o_err_cnt,
`ifdef MUL_ERR_STATS_SQERR_EN
  output logic [acc_width(2*PW, CNT_W)-1:0]  o_sum_se,
`endif
  output logic [CNT_W:0]                     o_sample_cnt
);

  localparam int unsigned    SumW    = acc_width(PW, CNT_W);
  localparam logic [CNT_W:0] LastCnt = (CNT_W+1)'(N_SAMPLES - 1);
  localparam logic [CNT_W:0] CntOne  = (CNT_W+1)'(1);

  state_e r_state, w_state_next;

  logic            w_accept;
  logic            w_clear;
  logic            w_pipe_busy;
  logic            w_v1;
  logic [PW-1:0]   w_d1;
  logic            w_ne1;
  logic            w_acc_v;
  logic [PW-1:0]   w_acc_d;
  logic            w_acc_ne;

  logic [SumW-1:0] r_sum_ae;
  logic [PW-1:0]   r_max_ae;
  logic [CNT_W:0]  r_err_cnt;
  logic [CNT_W:0]  r_sample_cnt;

  assign o_in_ready = (r_state == StRun);
  assign o_busy     = (r_state == StRun) || (r_state == StDrain);
  assign o_done     = (r_state == StDone);
  assign w_accept   = i_in_valid & o_in_ready;
  // A start outside IDLE/DONE is ignored; pipeline is always empty here.
  assign w_clear    = i_start && ((r_state == StIdle) || (r_state == StDone));

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle, StDone: if (i_start) w_state_next = StRun;
      StRun:          if (w_accept && (r_sample_cnt == LastCnt)) w_state_next = StDrain;
      StDrain:        if (!w_pipe_busy) w_state_next = StDone;
      default:        w_state_next = StIdle;
    endcase
  end

  // Accepted-pair counter.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_clear) r_sample_cnt <= '0;
    else if (w_accept)    r_sample_cnt <= r_sample_cnt + CntOne;
  end

  mul_err_absdiff #(
    .W (PW)
  ) u_s1 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (w_accept),
    .i_a     (i_in_approx),
    .i_b     (i_in_exact),
    .o_valid (w_v1),
    .o_d     (w_d1),
    .o_ne    (w_ne1)
  );

`ifdef MUL_ERR_STATS_SQERR_EN
  localparam int unsigned SeW = acc_width(2*PW, CNT_W);

  logic            r_v2;
  logic [PW-1:0]   r_d2;
  logic            r_ne2;
  logic [2*PW-1:0] r_sq2;
  logic [SeW-1:0]  r_sum_se;

  // Squaring stage; the other metrics ride along to keep them aligned.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v2  <= 1'b0;
      r_d2  <= '0;
      r_ne2 <= 1'b0;
      r_sq2 <= '0;
    end else begin
      r_v2 <= w_v1;
      if (w_v1) begin
        r_d2  <= w_d1;
        r_ne2 <= w_ne1;
        r_sq2 <= {{PW{1'b0}}, w_d1} * {{PW{1'b0}}, w_d1};
      end
    end
  end

  // Sum of squared error.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_clear) r_sum_se <= '0;
    else if (r_v2)        r_sum_se <= r_sum_se + {{CNT_W{1'b0}}, r_sq2};
  end

  assign w_acc_v     = r_v2;
  assign w_acc_d     = r_d2;
  assign w_acc_ne    = r_ne2;
  assign w_pipe_busy = w_v1 | r_v2;
  assign o_sum_se    = r_sum_se;
`else
  assign w_acc_v     = w_v1;
  assign w_acc_d     = w_d1;
  assign w_acc_ne    = w_ne1;
  assign w_pipe_busy = w_v1;
`endif

  // Accumulators for sum, max and mismatch count.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_clear) begin
      r_sum_ae  <= '0;
      r_max_ae  <= '0;
      r_err_cnt <= '0;
    end else if (w_acc_v) begin
      r_sum_ae  <= r_sum_ae + {{CNT_W{1'b0}}, w_acc_d};
      r_err_cnt <= r_err_cnt + {{CNT_W{1'b0}}, w_acc_ne};
      if (w_acc_d > r_max_ae) r_max_ae <= w_acc_d;
    end
  end

  assign o_sum_ae     = r_sum_ae;
  assign o_max_ae     = r_max_ae;
  assign o_err_cnt    = r_err_cnt;
  assign o_sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_mul_err_stats.sv
// Directed bench for mul_err_stats (instance A: CNT_W=16, instance B: CNT_W=2).
module tb_mul_err_stats;

`ifdef MUL_ERR_STATS_SQERR_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int last_acc = 0;
  int lat;

  // Instance A
  logic        rst, start, in_valid, in_ready, busy, done;
  logic [31:0] in_approx, in_exact, max_ae;
  logic [47:0] sum_ae;
  logic [16:0] err_cnt, sample_cnt;
`ifdef MUL_ERR_STATS_SQERR_EN
  logic [79:0] sum_se;
`endif

  // Instance B
  logic        rst_b, start_b, valid_b, ready_b, busy_b, done_b;
  logic [31:0] approx_b, exact_b, max_b;
  logic [33:0] sum_b;
  logic [2:0]  err_b, sample_b;
`ifdef MUL_ERR_STATS_SQERR_EN
  logic [65:0] sum_se_b;
`endif

  mul_err_stats #(.PW(32), .N_SAMPLES(4), .CNT_W(16)) u_dut_a (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_approx  (in_approx),
    .i_in_exact   (in_exact),
    .o_busy       (busy),
    .o_done       (done),
    .o_sum_ae     (sum_ae),
    .o_max_ae     (max_ae),
    .o_err_cnt    (err_cnt),
`ifdef MUL_ERR_STATS_SQERR_EN
    .o_sum_se     (sum_se),
`endif
    .o_sample_cnt (sample_cnt)
  );

  mul_err_stats #(.PW(32), .N_SAMPLES(4), .CNT_W(2)) u_dut_b (
    .i_clk        (clk),
    .i_rst        (rst_b),
    .i_start      (start_b),
    .i_in_valid   (valid_b),
    .o_in_ready   (ready_b),
    .i_in_approx  (approx_b),
    .i_in_exact   (exact_b),
    .o_busy       (busy_b),
    .o_done       (done_b),
    .o_sum_ae     (sum_b),
    .o_max_ae     (max_b),
    .o_err_cnt    (err_b),
`ifdef MUL_ERR_STATS_SQERR_EN
    .o_sum_se     (sum_se_b),
`endif
    .o_sample_cnt (sample_b)
  );

  task automatic start_run;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present a pair and return at the negedge after the accepting edge.
  task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_approx = a;
    in_exact  = b;
    in_valid  = 1'b1;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready got=%b exp=1", in_ready);
    end
    @(negedge clk);
    last_acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int l);
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    l = (done === 1'b1) ? (cyc - last_acc) : -1;
  endtask

  task automatic test_reset;
    int bad = 0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_approx = '0; in_exact = '0;
    rst_b = 1'b1; start_b = 1'b0; valid_b = 1'b0; approx_b = '0; exact_b = '0;
    @(negedge clk);
    rst = 1'b0; rst_b = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (sum_ae !== 48'd0) begin failures++; $display("FAIL rst_sum got=%0d exp=0", sum_ae); end
    checks++; if (max_ae !== 32'd0) begin failures++; $display("FAIL rst_max got=%0d exp=0", max_ae); end
    checks++; if (err_cnt !== 17'd0) begin failures++; $display("FAIL rst_err got=%0d exp=0", err_cnt); end
    checks++; if (sample_cnt !== 17'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", sample_cnt); end
`ifdef MUL_ERR_STATS_SQERR_EN
    checks++; if (sum_se !== 80'd0) begin failures++; $display("FAIL rst_sumse got=%0d exp=0", sum_se); end
`endif
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL idle_hold got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_basic;
    start_run();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL basic_run_state got=%b%b exp=11", in_ready, busy); end
    send_pair(32'd100, 32'd100);
    send_pair(32'd0, 32'd46006273);
    send_pair(32'd46006273, 32'd0);
    send_pair(32'd5, 32'd7);
    wait_done(lat);
    checks++; if (lat != LAT) begin failures++; $display("FAIL basic_lat got=%0d exp=%0d", lat, LAT); end
    checks++; if (sum_ae !== 48'd92012548) begin failures++; $display("FAIL basic_sum got=%0d exp=92012548", sum_ae); end
    checks++; if (max_ae !== 32'd46006273) begin failures++; $display("FAIL basic_max got=%0d exp=46006273", max_ae); end
    checks++; if (err_cnt !== 17'd3) begin failures++; $display("FAIL basic_err got=%0d exp=3", err_cnt); end
    checks++; if (sample_cnt !== 17'd4) begin failures++; $display("FAIL basic_cnt got=%0d exp=4", sample_cnt); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL basic_done_state got=%b%b exp=00", busy, in_ready); end
  endtask

  task automatic test_gaps;
    start_run();
    checks++; if (sum_ae !== 48'd0 || sample_cnt !== 17'd0 || done !== 1'b0) begin
      failures++; $display("FAIL gaps_clear got=%0d/%0d/%b exp=0/0/0", sum_ae, sample_cnt, done); end
    send_pair(32'd100, 32'd100);
    repeat (2) @(negedge clk);
    send_pair(32'd0, 32'd46006273);
    repeat (2) @(negedge clk);
    send_pair(32'd46006273, 32'd0);
    repeat (2) @(negedge clk);
    send_pair(32'd5, 32'd7);
    // Fifth pair offered while draining.
    in_approx = 32'd1000; in_exact = 32'd1; in_valid = 1'b1;
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL gaps_drain got=%b%b exp=01", in_ready, busy); end
    wait_done(lat);
    checks++; if (lat != LAT) begin failures++; $display("FAIL gaps_lat got=%0d exp=%0d", lat, LAT); end
    checks++; if (sum_ae !== 48'd92012548) begin failures++; $display("FAIL gaps_sum got=%0d exp=92012548", sum_ae); end
    checks++; if (max_ae !== 32'd46006273) begin failures++; $display("FAIL gaps_max got=%0d exp=46006273", max_ae); end
    checks++; if (err_cnt !== 17'd3) begin failures++; $display("FAIL gaps_err got=%0d exp=3", err_cnt); end
    repeat (3) @(negedge clk);
    checks++; if (sample_cnt !== 17'd4 || in_ready !== 1'b0 || done !== 1'b1) begin
      failures++; $display("FAIL gaps_fifth got=%0d/%b/%b exp=4/0/1", sample_cnt, in_ready, done); end
    checks++; if (sum_ae !== 48'd92012548) begin failures++; $display("FAIL gaps_frozen got=%0d exp=92012548", sum_ae); end
    in_valid = 1'b0;
  endtask

  task automatic test_start_ignored;
    start_run();
    send_pair(32'd5, 32'd7);
    send_pair(32'd10, 32'd7);
    repeat (3) @(negedge clk);
    start_run();
    checks++; if (sample_cnt !== 17'd2 || sum_ae !== 48'd5 || err_cnt !== 17'd2) begin
      failures++; $display("FAIL ign_keep got=%0d/%0d/%0d exp=2/5/2", sample_cnt, sum_ae, err_cnt); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ign_busy got=%b exp=1", busy); end
    send_pair(32'd100, 32'd100);
    send_pair(32'd0, 32'd3);
    wait_done(lat);
    checks++; if (lat != LAT) begin failures++; $display("FAIL ign_lat got=%0d exp=%0d", lat, LAT); end
    checks++; if (sum_ae !== 48'd8 || max_ae !== 32'd3) begin
      failures++; $display("FAIL ign_sum_max got=%0d/%0d exp=8/3", sum_ae, max_ae); end
    checks++; if (err_cnt !== 17'd3 || sample_cnt !== 17'd4) begin
      failures++; $display("FAIL ign_counts got=%0d/%0d exp=3/4", err_cnt, sample_cnt); end
  endtask

  task automatic test_rst_mid;
    start_run();
    send_pair(32'd1, 32'd2);
    send_pair(32'd9, 32'd4);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL mid_state got=%b%b%b exp=000", busy, in_ready, done); end
    repeat (3) @(negedge clk);
    checks++; if (sum_ae !== 48'd0 || max_ae !== 32'd0 || err_cnt !== 17'd0 || sample_cnt !== 17'd0) begin
      failures++; $display("FAIL mid_clear got=%0d/%0d/%0d/%0d exp=0/0/0/0",
                           sum_ae, max_ae, err_cnt, sample_cnt); end
    start_run();
    send_pair(32'd100, 32'd100);
    send_pair(32'd0, 32'd46006273);
    send_pair(32'd46006273, 32'd0);
    send_pair(32'd5, 32'd7);
    wait_done(lat);
    checks++; if (sum_ae !== 48'd92012548 || err_cnt !== 17'd3 || sample_cnt !== 17'd4) begin
      failures++; $display("FAIL mid_rerun got=%0d/%0d/%0d exp=92012548/3/4", sum_ae, err_cnt, sample_cnt); end
  endtask

  task automatic test_max_mag;
    int n = 0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    approx_b = 32'hFFFF_FFFF; exact_b = 32'd0; valid_b = 1'b1;
    repeat (4) @(negedge clk);
    valid_b = 1'b0;
    while (done_b !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (done_b !== 1'b1) begin failures++; $display("FAIL max_done got=%b exp=1", done_b); end
    checks++; if (sum_b !== 34'h3_FFFF_FFFC) begin failures++; $display("FAIL max_sum got=%h exp=3fffffffc", sum_b); end
    checks++; if (max_b !== 32'hFFFF_FFFF) begin failures++; $display("FAIL max_max got=%h exp=ffffffff", max_b); end
    checks++; if (err_b !== 3'd4 || sample_b !== 3'd4) begin
      failures++; $display("FAIL max_counts got=%0d/%0d exp=4/4", err_b, sample_b); end
`ifdef MUL_ERR_STATS_SQERR_EN
    checks++; if (sum_se_b !== 66'h3_FFFF_FFF8_0000_0004) begin
      failures++; $display("FAIL max_sumse got=%h exp=3fffffff800000004", sum_se_b); end
`endif
  endtask

`ifdef MUL_ERR_STATS_SQERR_EN
  task automatic test_sqerr;
    start_run();
    send_pair(32'd5, 32'd7);
    send_pair(32'd10, 32'd7);
    send_pair(32'd3, 32'd3);
    send_pair(32'd8, 32'd8);
    wait_done(lat);
    checks++; if (lat != 3) begin failures++; $display("FAIL sq_lat got=%0d exp=3", lat); end
    checks++; if (sum_se !== 80'd13) begin failures++; $display("FAIL sq_sum got=%0d exp=13", sum_se); end
    checks++; if (sum_ae !== 48'd5 || err_cnt !== 17'd2) begin
      failures++; $display("FAIL sq_ae got=%0d/%0d exp=5/2", sum_ae, err_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_start_ignored();
    test_rst_mid();
    test_max_mag();
`ifdef MUL_ERR_STATS_SQERR_EN
    test_sqerr();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
